top_level: RTL and testbench
============================

// Module: top_level
// PURPOSE
//  Top of a minimal 4-bit-opcode CPU: program RAM with a host load port, 16-entry register file,
//  ALU, data RAM and a return-address stack. The host fills program RAM while W=1; on W=0 the
//  core executes one instruction per clock from PC=0. The block has no outputs; state is checked hierarchically.
// PARAMETERS
//  SIZE        8   data/register width (bits)
//  DATA_SIZE   16  instruction word width; fixed layout needs 16
//  ADDR_SIZE   5   program address width (32 words); also PC width
//  STACK_SIZE  4   return-stack depth (entries)
// PORTS
//  clk      in  1          single clock, all state on rising edge
//  rstn     in  1          asynchronous, active-low reset
//  W        in  1          1 = load mode: write DATA_WR to pmem[ADDR] every posedge, core halted
//  ADDR     in  ADDR_SIZE  program RAM write address
//  DATA_WR  in  DATA_SIZE  program RAM write data
// BEHAVIOUR
//  Instruction = {op[15:12], mop[11:8], L[7:4], R[3:0]}.
//  Reset (async, rstn=0):
//   - clears pc, all 16 regs, dmem (16 x SIZE), pmem (all 0 = NOP/NONE), stack and sp=0, flags C/Z.
//  W=1:
//   - pmem written; pc held at 0; no register/dmem/stack update.
//   - Writes with unknown ADDR are ignored.
//  W=0:
//   - Combinational fetch of pmem[pc], execute, commit on posedge.
//   - Default pc<=pc+1, wrapping 31->0.
//  Ops (R[x] = register x):
//   NOP: mop NONE -> nothing; REG_TO_REG -> R[L]<=R[R]; MEM_TO_REG -> R[L]<=dmem[R];
//        OP_REG -> nothing.
//   ADD R[L]<=R[L]+R[R]. SUB R[L]<=R[L]-R[R]. INC R[L]<=R[R]+1. DEC R[L]<=R[R]-1.
//   AND/OR/XOR R[L]<=R[L] op R[R]. NOT R[L]<=~R[R].
//   - All arithmetic is modulo 2^SIZE.
//   - C = carry out (ADD/INC) or borrow (SUB/DEC); Z = result==0.
//   - Flags change only on ALU ops.
//   ST: mop OP_REG -> dmem[L]<=R[R]; mop NONE -> dmem[L]<=zero-ext immediate R.
//   LD: R[R]<=dmem[L] (any mop).
//   JMP (call): push pc+1 and set pc<=zero-ext R.
//    - Stack full: push dropped, jump still taken.
//   RTN: pop, pc<=top.
//    - Stack empty: pc<=pc+1.
//  Other mop values are treated as NONE. Unused op codes act as NOP.
//  Latency: every instruction completes in 1 cycle.
//   - A register or dmem write is visible to the next instruction.
// STRUCTURE
//  Shared package cpu_pkg:
//   - op codes: NOP=0 ADD=1 SUB=2 INC=3 DEC=4 AND=5 OR=6 XOR=7 NOT=8 LD=9 ST=A JMP=B RTN=C.
//   - mop codes: NONE=0 REG_TO_REG=1 MEM_TO_REG=2 OP_REG=3.
//   - field-slice helper.
//  Sub-module cpu_alu:
//   - combinational; inputs (op, a, b), outputs (result, carry, zero).
//  Everything else stays in top_level.
// TESTING
//  1. Reset mid-run, then load pmem[0..13] and release W.
//     -> pc=0 on the first executing cycle; all regs/dmem are 0.
//  2. Program INC 2,1; ADD 3,2; NOP.R2R 0,1; NOP.R2R 2,3
//     -> R2=1, R3=1, R0=0, then R2=1.
//  3. ST.OPREG 6,0 / ST.NONE 7,5 / LD 7,4
//     -> dmem[6]=R0, dmem[7]=5, R4=5 one cycle after LD.
//  4. JMP 11,11 at 9; 11 ADD 3,2; 12 SUB 3,2; 13 RTN (R2=1, R3=1).
//     -> pc sequence 9,11,12,13,10,11,12,13.
//     -> R3 values 2,1,2,3,2.
//     -> second RTN with empty stack -> pc=14.
//  5. Five nested JMPs without RTN -> sp saturates at 4, 5th return address lost.
//     Run a NOP-filled pmem -> pc wraps 31->0.
//  6. ADD with R[L]=0xFF, R[R]=0x01 -> result 0x00, C=1, Z=1.
//     SUB 0x00-0x01 -> 0xFF, C=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU: opcode/mop encodings, instruction layout
// and the field-slice helper used by the core.
package cpu_pkg;

    localparam int INSTR_W    = 16;
    localparam int NUM_REGS   = 16;
    localparam int DMEM_DEPTH = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_INC = 4'h3,
        OP_DEC = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_LD  = 4'h9,
        OP_ST  = 4'hA,
        OP_JMP = 4'hB,
        OP_RTN = 4'hC
    } op_e;

    typedef enum logic [3:0] {
        MOP_NONE       = 4'h0,
        MOP_REG_TO_REG = 4'h1,
        MOP_MEM_TO_REG = 4'h2,
        MOP_OP_REG     = 4'h3
    } mop_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] mop;
        logic [3:0] l;
        logic [3:0] r;
    } instr_t;

    function automatic instr_t slice_instr(input logic [INSTR_W-1:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic is modulo 2^SIZE, carry is carry-out for ADD/INC and
// borrow for SUB/DEC; logic ops report carry as 0.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [3:0]      i_op,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    output logic [SIZE-1:0] o_result,
    output logic            o_carry,
    output logic            o_zero
);

    localparam logic [SIZE:0] ONE = {{SIZE{1'b0}}, 1'b1};

    logic [SIZE:0] w_wide;

    // NOTE: w_wide gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_INC:  w_wide = {1'b0, i_b} + ONE;
            OP_DEC:  w_wide = {1'b0, i_b} - ONE;
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            OP_NOT:  w_wide = {1'b0, ~i_b};
            default: w_wide = '0;
        endcase
    end

    assign o_result = w_wide[SIZE-1:0];
    assign o_carry  = w_wide[SIZE];
    assign o_zero   = (o_result == '0);

endmodule

// File: rtl/top_level.sv
// Minimal CPU core: host-loadable program RAM, 16-entry register file, data RAM and a
// saturating return-address stack; executes one instruction per clock when W=0.
module top_level
    import cpu_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int STACK_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 W,
    input  logic [ADDR_SIZE-1:0] ADDR,
    input  logic [DATA_SIZE-1:0] DATA_WR
);

    localparam int PMEM_DEPTH = 1 << ADDR_SIZE;
    localparam int SP_W       = $clog2(STACK_SIZE + 1);
    localparam int STK_AW     = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;

    logic [DATA_SIZE-1:0] r_pmem  [PMEM_DEPTH];
    logic [SIZE-1:0]      r_regs  [NUM_REGS];
    logic [SIZE-1:0]      r_dmem  [DMEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_stack [STACK_SIZE];
    logic [SP_W-1:0]      r_sp;
    logic [ADDR_SIZE-1:0] r_pc;
    logic                 r_c;
    logic                 r_z;

    instr_t               w_instr;
    logic [SIZE-1:0]      w_reg_l;
    logic [SIZE-1:0]      w_reg_r;
    logic [SIZE-1:0]      w_imm;
    logic [ADDR_SIZE-1:0] w_pc_inc;
    logic [ADDR_SIZE-1:0] w_jmp_target;
    logic [ADDR_SIZE-1:0] w_pc_next;
    logic [SP_W-1:0]      w_sp_dec;
    logic                 w_stack_full;
    logic                 w_stack_empty;
    logic [SIZE-1:0]      w_alu_result;
    logic                 w_alu_carry;
    logic                 w_alu_zero;

    assign w_instr       = slice_instr(r_pmem[r_pc][INSTR_W-1:0]);
    assign w_reg_l       = r_regs[w_instr.l];
    assign w_reg_r       = r_regs[w_instr.r];
    assign w_imm         = {{(SIZE-4){1'b0}}, w_instr.r};
    assign w_pc_inc      = r_pc + 1'b1;
    assign w_jmp_target  = {{(ADDR_SIZE-4){1'b0}}, w_instr.r};
    assign w_sp_dec      = r_sp - 1'b1;
    assign w_stack_full  = (r_sp == SP_W'(STACK_SIZE));
    assign w_stack_empty = (r_sp == '0);

    cpu_alu #(.SIZE(SIZE)) u_alu (
        .i_op     (w_instr.op),
        .i_a      (w_reg_l),
        .i_b      (w_reg_r),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    // JMP is taken even when the push is dropped; RTN on an empty stack falls through.
    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_instr.op == OP_JMP)
            w_pc_next = w_jmp_target;
        else if (w_instr.op == OP_RTN && !w_stack_empty)
            w_pc_next = r_stack[w_sp_dec[STK_AW-1:0]];
    end

    // NOTE: the memories are reset explicitly so program RAM comes up as NOPs; this keeps
    // them as flops rather than RAM macros, which is intended at these depths.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= '0;
            r_sp <= '0;
            r_c  <= 1'b0;
            r_z  <= 1'b0;
            for (int i = 0; i < PMEM_DEPTH; i++) r_pmem[i]  <= '0;
            for (int i = 0; i < NUM_REGS; i++)   r_regs[i]  <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i]  <= '0;
            for (int i = 0; i < STACK_SIZE; i++) r_stack[i] <= '0;
        end else if (W) begin
            r_pc         <= '0;
            r_pmem[ADDR] <= DATA_WR;
        end else begin
            r_pc <= w_pc_next;
            case (w_instr.op)
                OP_NOP: begin
                    if (w_instr.mop == MOP_REG_TO_REG)
                        r_regs[w_instr.l] <= w_reg_r;
                    else if (w_instr.mop == MOP_MEM_TO_REG)
                        r_regs[w_instr.l] <= r_dmem[w_instr.r];
                end
                OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    r_regs[w_instr.l] <= w_alu_result;
                    r_c               <= w_alu_carry;
                    r_z               <= w_alu_zero;
                end
                OP_LD: r_regs[w_instr.r] <= r_dmem[w_instr.l];
                OP_ST: begin
                    if (w_instr.mop == MOP_OP_REG)
                        r_dmem[w_instr.l] <= w_reg_r;
                    else
                        r_dmem[w_instr.l] <= w_imm;
                end
                OP_JMP: begin
                    if (!w_stack_full) begin
                        r_stack[r_sp[STK_AW-1:0]] <= w_pc_inc;
                        r_sp                      <= r_sp + 1'b1;
                    end
                end
                OP_RTN: begin
                    if (!w_stack_empty)
                        r_sp <= w_sp_dec;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: loads programs through the host port, then walks
// per-cycle expectation tables through a scoreboard and inspects core state hierarchically.
module tb_top_level;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        W = 1'b0;
    logic [4:0]  ADDR = '0;
    logic [15:0] DATA_WR = '0;

    int checks = 0;
    int errors = 0;

    typedef enum {K_REG, K_DMEM, K_SP, K_PC, K_STK} kind_e;

    typedef struct {
        string      name;
        logic [4:0] pc;
        kind_e      kind;
        int         idx;
        logic [7:0] val;
        bit         chk_flags;
        bit         c;
        bit         z;
    } row_t;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] word;
    } load_t;

    row_t  rows[$];
    row_t  sb[$];
    load_t prog[$];

    top_level dut (
        .clk     (clk),
        .rstn    (rstn),
        .W       (W),
        .ADDR    (ADDR),
        .DATA_WR (DATA_WR)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input string n, input logic [4:0] pc, input kind_e k,
                                input int idx, input logic [7:0] v,
                                input bit f = 1'b0, input bit c = 1'b0, input bit z = 1'b0);
        row_t r;
        r.name = n; r.pc = pc; r.kind = k; r.idx = idx; r.val = v;
        r.chk_flags = f; r.c = c; r.z = z;
        return r;
    endfunction

    function automatic load_t ld(input logic [4:0] a, input logic [15:0] w);
        load_t l;
        l.addr = a; l.word = w;
        return l;
    endfunction

    // Writes every entry of prog, then drops W just after the last write edge.
    task automatic load_program();
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            W = 1'b1; ADDR = prog[i].addr; DATA_WR = prog[i].word;
            if (i > 0) check($sformatf("load_pc_held_%0d", i), 32'(dut.r_pc), 32'd0);
        end
        @(posedge clk);
        #1;
        W = 1'b0;
        prog.delete();
    endtask

    task automatic run_rows();
        row_t r;
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            check({rows[i].name, "_pc"}, 32'(dut.r_pc), 32'(rows[i].pc));
            sb.push_back(rows[i]);
            @(posedge clk);
            #1;
            r = sb.pop_front();
            case (r.kind)
                K_REG:  check({r.name, "_reg"},  32'(dut.r_regs[r.idx]),  32'(r.val));
                K_DMEM: check({r.name, "_dmem"}, 32'(dut.r_dmem[r.idx]),  32'(r.val));
                K_SP:   check({r.name, "_sp"},   32'(dut.r_sp),           32'(r.val));
                K_PC:   check({r.name, "_npc"},  32'(dut.r_pc),           32'(r.val));
                K_STK:  check({r.name, "_stk"},  32'(dut.r_stack[r.idx]), 32'(r.val));
                default: ;
            endcase
            if (r.chk_flags) begin
                check({r.name, "_c"}, 32'(dut.r_c), 32'(r.c));
                check({r.name, "_z"}, 32'(dut.r_z), 32'(r.z));
            end
        end
        rows.delete();
    endtask

    task automatic check_all_zero(input string name);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (dut.r_regs[i] !== 8'h00) bad++;
            if (dut.r_dmem[i] !== 8'h00) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        // Power-on reset: state cleared, pmem is all NOP.
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(dut.r_pc), 32'd0);
        check("rst_sp", 32'(dut.r_sp), 32'd0);
        check("rst_flags", {30'd0, dut.r_c, dut.r_z}, 32'd0);
        check("rst_pmem", 32'(dut.r_pmem[17]), 32'd0);
        check_all_zero("rst_regs_dmem");

        // NOP-filled pmem: pc counts up and wraps 31 -> 0.
        rstn = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 31 || i == 32 || i == 33)
                check($sformatf("wrap_pc_%0d", i), 32'(dut.r_pc), 32'(i % 32));
            @(negedge clk);
        end

        // Mid-run asynchronous reset.
        check("pre_reset_pc", 32'(dut.r_pc), 32'd2);
        #2 rstn = 1'b0;
        #1 check("async_reset_pc", 32'(dut.r_pc), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        prog.push_back(ld(5'd0,  16'h3021));   // INC 2,1
        prog.push_back(ld(5'd1,  16'h1032));   // ADD 3,2
        prog.push_back(ld(5'd2,  16'h0101));   // NOP.R2R 0,1
        prog.push_back(ld(5'd3,  16'h0123));   // NOP.R2R 2,3
        prog.push_back(ld(5'd4,  16'hA360));   // ST.OPREG 6,0
        prog.push_back(ld(5'd5,  16'hA075));   // ST.NONE 7,5
        prog.push_back(ld(5'd6,  16'h9074));   // LD 7,4
        prog.push_back(ld(5'd7,  16'h0000));
        prog.push_back(ld(5'd8,  16'h0000));
        prog.push_back(ld(5'd9,  16'hB0BB));   // JMP 11
        prog.push_back(ld(5'd10, 16'h3033));   // INC 3,3
        prog.push_back(ld(5'd11, 16'h1032));   // ADD 3,2
        prog.push_back(ld(5'd12, 16'h2032));   // SUB 3,2
        prog.push_back(ld(5'd13, 16'hC000));   // RTN
        load_program();
        check("loaded_pc", 32'(dut.r_pc), 32'd0);
        check("loaded_pmem9", 32'(dut.r_pmem[9]), 32'h0000B0BB);
        check_all_zero("load_no_exec");

        rows.push_back(mk("inc",       5'd0,  K_REG,  2, 8'd1));
        rows.push_back(mk("add",       5'd1,  K_REG,  3, 8'd1, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk("r2r_0",     5'd2,  K_REG,  0, 8'd0));
        rows.push_back(mk("r2r_2",     5'd3,  K_REG,  2, 8'd1));
        rows.push_back(mk("st_reg",    5'd4,  K_DMEM, 6, 8'd0));
        rows.push_back(mk("st_imm",    5'd5,  K_DMEM, 7, 8'd5));
        rows.push_back(mk("ld",        5'd6,  K_REG,  4, 8'd5));
        rows.push_back(mk("nop7",      5'd7,  K_REG,  4, 8'd5));
        rows.push_back(mk("nop8",      5'd8,  K_SP,   0, 8'd0));
        rows.push_back(mk("jmp",       5'd9,  K_SP,   0, 8'd1));
        rows.push_back(mk("add_a",     5'd11, K_REG,  3, 8'd2));
        rows.push_back(mk("sub_a",     5'd12, K_REG,  3, 8'd1, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk("rtn",       5'd13, K_PC,   0, 8'd10));
        rows.push_back(mk("inc3",      5'd10, K_REG,  3, 8'd2));
        rows.push_back(mk("add_b",     5'd11, K_REG,  3, 8'd3));
        rows.push_back(mk("sub_b",     5'd12, K_REG,  3, 8'd2));
        rows.push_back(mk("rtn_empty", 5'd13, K_PC,   0, 8'd14));
        rows.push_back(mk("nop14",     5'd14, K_SP,   0, 8'd0));
        run_rows();

        // Five nested calls: the stack saturates and the fifth return address is lost.
        for (int i = 0; i < 5; i++) prog.push_back(ld(5'(i), 16'hB000 | 16'(i + 1)));
        load_program();
        for (int i = 0; i < 5; i++)
            rows.push_back(mk($sformatf("call%0d", i + 1), 5'(i), K_SP, 0, 8'((i < 4) ? i + 1 : 4)));
        run_rows();
        check("call_pc", 32'(dut.r_pc), 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("call_stk%0d", i), 32'(dut.r_stack[i]), 32'(i + 1));

        // Wrap-around arithmetic and flags; a following JMP leaves flags alone.
        prog.push_back(ld(5'd0, 16'h4050));    // DEC 5,0
        prog.push_back(ld(5'd1, 16'h3060));    // INC 6,0
        prog.push_back(ld(5'd2, 16'h1056));    // ADD 5,6
        prog.push_back(ld(5'd3, 16'h2056));    // SUB 5,6
        load_program();
        rows.push_back(mk("dec_wrap",  5'd0, K_REG, 5, 8'hFF, 1'b1, 1'b1, 1'b0));
        rows.push_back(mk("inc_one",   5'd1, K_REG, 6, 8'h01, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk("add_wrap",  5'd2, K_REG, 5, 8'h00, 1'b1, 1'b1, 1'b1));
        rows.push_back(mk("sub_wrap",  5'd3, K_REG, 5, 8'hFF, 1'b1, 1'b1, 1'b0));
        rows.push_back(mk("jmp_full",  5'd4, K_PC,  0, 8'd5,  1'b1, 1'b1, 1'b0));
        run_rows();
        check("full_sp", 32'(dut.r_sp), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
